// File: rtl/instr_encode_loader_pkg.sv
// instr_encode_loader_pkg: shared opcodes, field widths, error codes and FSM states for the program loader.
package instr_encode_loader_pkg;
    localparam logic [2:0] OP_LW   = 3'b000;
    localparam logic [2:0] OP_SW   = 3'b001;
    localparam logic [2:0] OP_JUMP = 3'b010;
    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam int IMM_W   = 3;
    localparam int JADDR_W = 5;
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_OVF   = 2'd2;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_t;
endpackage

// File: rtl/instr_field_pack.sv
// instr_field_pack: packs opcode/register/value fields into an 8-bit word and flags values too wide for their field.
module instr_field_pack
    import instr_encode_loader_pkg::*;
(
    input  logic [2:0] i_op,
    input  logic [1:0] i_rfield,
    input  logic [7:0] i_value,
    output logic [7:0] o_word,
    output logic       o_range_err
);
    logic w_itype;
    always_comb begin
        w_itype     = (i_op == OP_LW) || (i_op == OP_SW) || (i_op == OP_ADDI);
        o_word      = w_itype ? {i_op, i_rfield, i_value[IMM_W-1:0]} : {i_op, i_value[JADDR_W-1:0]};
        o_range_err = w_itype ? |i_value[7:IMM_W] : |i_value[7:JADDR_W];
    end
endmodule

// File: rtl/instr_encode_loader.sv
// instr_encode_loader: accepts instruction field bundles and writes packed words to instruction memory from address 0.
module instr_encode_loader
    import instr_encode_loader_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [1:0]        in_rfield,
    input  logic [7:0]        in_value,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);
    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

    state_t              r_state;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_mem_wdata;
    logic                r_done;
    logic                r_error;
    logic [1:0]          r_err_code;
    logic [ADDR_W:0]     r_count;
    logic [7:0]          w_word;
    logic                w_range_err;

    instr_field_pack u_pack (
        .i_op        (in_op),
        .i_rfield    (in_rfield),
        .i_value     (in_value),
        .o_word      (w_word),
        .o_range_err (w_range_err)
    );

    assign in_ready   = (r_state == S_LOAD);
    assign busy       = (r_state == S_LOAD);
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign done       = r_done;
    assign error      = r_error;
    assign err_code   = r_err_code;
    assign word_count = r_count;

    // word_count doubles as the next write address; it never exceeds DEPTH so the address cannot wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_count     <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_LOAD: if (in_valid) begin
                    r_mem_addr <= r_count[ADDR_W-1:0];
                    if (w_range_err) begin
                        r_state    <= S_ERROR;
                        r_error    <= 1'b1;
                        r_err_code <= ERR_RANGE;
                    end else begin
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_word;
                        r_count     <= r_count + (ADDR_W+1)'(1);
                        if (in_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (r_count == LAST_ADDR) begin
                            r_state    <= S_ERROR;
                            r_error    <= 1'b1;
                            r_err_code <= ERR_OVF;
                        end
                    end
                end
                default: if (start) begin
                    r_state    <= S_LOAD;
                    r_count    <= '0;
                    r_mem_addr <= '0;
                    r_done     <= 1'b0;
                    r_error    <= 1'b0;
                    r_err_code <= ERR_NONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encode_loader.sv
// tb_instr_encode_loader: randomized scoreboard bench comparing memory writes and status against an arithmetic model.
module tb_instr_encode_loader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = '0;
    logic [1:0] in_rfield = '0;
    logic [7:0] in_value = '0;
    logic       in_last = 1'b0;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       busy, done, error;
    logic [1:0] err_code;
    logic [5:0] word_count;

    instr_encode_loader #(.ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rfield(in_rfield), .in_value(in_value), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .done(done), .error(error), .err_code(err_code), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {int a; int d; int c;} wr_t;
    wr_t exp_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;

    // high-level model of the load session
    bit m_loading = 0, m_done = 0, m_err = 0;
    int m_code = 0, m_count = 0, m_err_addr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (!reset && mem_we) begin
            if (exp_q.size() == 0) chk("spurious_write", 1, 0);
            else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", int'(mem_addr), e.a);
                chk("wr_data", int'(mem_wdata), e.d);
                chk("wr_cycle", cyc, e.c);
            end
        end
    end

    function automatic void encode(input int op, input int rf, input int v, output int w, output bit bad);
        if (op == 0 || op == 1 || op == 4) begin
            w = op * 32 + rf * 8 + v % 8;
            bad = v >= 8;
        end else begin
            w = op * 32 + v % 32;
            bad = v >= 32;
        end
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (!m_loading) begin
            m_loading = 1; m_done = 0; m_err = 0; m_code = 0; m_count = 0;
        end
        chk("start_count", int'(word_count), m_count);
        chk("start_done", int'(done), int'(m_done));
        chk("start_busy", int'(busy), 1);
    endtask

    task automatic send(input int op, input int rf, input int v, input bit last, input int gap);
        int w;
        bit bad;
        bit rdy;
        bit ok;
        repeat (gap) begin @(posedge clk); #1; end
        in_op = 3'(op); in_rfield = 2'(rf); in_value = 8'(v); in_last = last;
        in_valid = 1'b1;
        if (!m_loading) begin
            repeat (3) begin @(posedge clk); #1; end
            chk("not_ready_when_idle", int'(in_ready), 0);
        end else begin
            ok = 0;
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk);
                rdy = in_ready;
                @(posedge clk); #1;
                ok = rdy;
            end
            if (!ok) chk("accept_timeout", 0, 1);
            else begin
                encode(op, rf, v, w, bad);
                if (bad) begin
                    m_loading = 0; m_err = 1; m_code = 1; m_err_addr = m_count;
                end else begin
                    exp_q.push_back('{m_count, w, cyc});
                    m_count++;
                    if (last) begin m_loading = 0; m_done = 1; end
                    else if (m_count == 32) begin m_loading = 0; m_err = 1; m_code = 2; end
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic settle_check();
        repeat (2) begin @(posedge clk); #1; end
        chk("done", int'(done), int'(m_done));
        chk("error", int'(error), int'(m_err));
        chk("err_code", int'(err_code), m_code);
        chk("word_count", int'(word_count), m_count);
        chk("busy", int'(busy), int'(m_loading));
        chk("in_ready", int'(in_ready), int'(m_loading));
        if (m_err && m_code == 1) chk("err_addr", int'(mem_addr), m_err_addr);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    function automatic int rand_value();
        int k;
        k = $urandom_range(0, 9);
        if (k == 0) return $urandom_range(0, 255);
        if (k == 1) return ($urandom_range(0, 1) == 0) ? 8 : 32;
        return $urandom_range(0, 7);
    endfunction

    task automatic zero_outputs(input string tag);
        chk({tag, "_we"}, int'(mem_we), 0);
        chk({tag, "_addr"}, int'(mem_addr), 0);
        chk({tag, "_wdata"}, int'(mem_wdata), 0);
        chk({tag, "_ready"}, int'(in_ready), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_flags"}, int'({done, error, err_code}), 0);
        chk({tag, "_count"}, int'(word_count), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        zero_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // single addi -> 0x95
        pulse_start();
        send(4, 2, 5, 1, 0);
        settle_check();

        // back-to-back writes 0x03, 0x5F, 0x2F
        pulse_start();
        send(0, 0, 3, 0, 0);
        send(2, 3, 31, 0, 0);
        send(1, 1, 7, 1, 0);
        settle_check();

        // range error on second word
        pulse_start();
        send(4, 1, 2, 0, 0);
        send(4, 0, 8, 0, 0);
        settle_check();
        send(4, 0, 1, 0, 0);

        // overflow: 32 words without last
        pulse_start();
        for (int i = 0; i < 32; i++) send(i % 8, $urandom_range(0, 3), $urandom_range(0, 7), 0, 0);
        settle_check();
        send(0, 0, 1, 1, 0);
        settle_check();

        // stalls and start mid-load
        pulse_start();
        send(1, 2, 4, 0, 2);
        send(5, 0, 17, 0, 1);
        pulse_start();
        send(3, 0, 9, 0, 3);
        send(2, 0, 30, 1, 1);
        settle_check();

        // randomized programs
        for (int p = 0; p < 10; p++) begin
            pulse_start();
            for (int i = 0; i < 40 && m_loading; i++) begin
                if ($urandom_range(0, 15) == 0) pulse_start();
                send($urandom_range(0, 7), $urandom_range(0, 3), rand_value(),
                     $urandom_range(0, 11) == 0, $urandom_range(0, 2));
            end
            settle_check();
        end

        // asynchronous reset in the middle of a load
        pulse_start();
        send(4, 3, 6, 0, 0);
        send(0, 1, 2, 0, 0);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        zero_outputs("async_reset");
        chk("queue_drained_at_reset", exp_q.size(), 0);
        m_loading = 0; m_done = 0; m_err = 0; m_code = 0; m_count = 0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        zero_outputs("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
